approx_err_monitor: RTL

APPROX_ERR_MONITOR -- requirements
Module: approx_err_monitor

---
 rtl/approx_pkg.sv | 19 +
 rtl/approx_err_dist.sv | 19 +
 rtl/approx_err_monitor.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/approx_pkg.sv
// Shared definitions for the approximate-adder error monitor.
//   state_t   : monitor FSM states (IDLE, RUN, DRAIN, DONE)
//   OPW       : operand width of the monitored adder (4)
//   SUMW      : exact/approximate sum width (5)
//   HIST_BINS : number of error-distance histogram bins (8)
//   CNT_W     : width of the error counter and of each histogram bin (16)
package approx_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int OPW       = 4;
  localparam int SUMW      = 5;
  localparam int HIST_BINS = 8;
  localparam int CNT_W     = 16;
endpackage

// File: rtl/approx_err_dist.sv
// Combinational exact sum and error distance for one sample.
//   a_i, b_i : operands fed to the approximate adder
//   y_i      : approximate sum produced for a_i + b_i
//   exact_o  : a_i + b_i, zero-extended to SUMW bits
//   ed_o     : |exact_o - y_i|
module approx_err_dist
  import approx_pkg::*;
(
  input  logic [OPW-1:0]  a_i,
  input  logic [OPW-1:0]  b_i,
  input  logic [SUMW-1:0] y_i,
  output logic [SUMW-1:0] exact_o,
  output logic [SUMW-1:0] ed_o
);
  always_comb begin
    exact_o = SUMW'(a_i) + SUMW'(b_i);
    ed_o    = (exact_o >= y_i) ? (exact_o - y_i) : (y_i - exact_o);
  end
endmodule

// File: rtl/approx_err_monitor.sv
// Windowed error monitor for an approximate 4-bit adder.
// Optional histogram output enabled by macro APPROX_ERR_HIST_EN.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; ready never depends combinationally on valid.
//   in  : in_valid/in_ready, in_ready high only in RUN
//   out : res_valid/res_ready, results held stable while res_valid is high
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : pulse opening a window (only honoured in IDLE)
//   in_valid/in_ready : sample handshake
//   a, b, y_apx       : operands and approximate sum of one sample
//   res_valid/ready   : result handshake
//   err_cnt           : samples with nonzero error (saturating)
//   err_sum           : sum of error distances (saturating)
//   err_max           : largest error distance seen
//   hist              : per-bin ED counts, ED>=7 in bin 7 (optional)
//   dbg_state         : current FSM state, for observation
module approx_err_monitor
  import approx_pkg::*;
#(
  parameter int WIN   = 256,
  parameter int SUM_W = 24
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [3:0]                  a,
  input  logic [3:0]                  b,
  input  logic [4:0]                  y_apx,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [15:0]                 err_cnt,
  output logic [SUM_W-1:0]            err_sum,
  output logic [4:0]                  err_max,
`ifdef APPROX_ERR_HIST_EN
  output logic [HIST_BINS-1:0][CNT_W-1:0] hist,
`endif
  output logic [1:0]                  dbg_state
);
  state_t            state_q;
  logic              in_ready_q, res_valid_q;
  logic [15:0]       smp_cnt_q;
  logic              accept, win_clear;

  // stage 0: registered sample; stage 1: registered error distance
  logic              s0_v_q, s1_v_q;
  logic [OPW-1:0]    a_q, b_q;
  logic [SUMW-1:0]   y_q, ed_q;
  logic [SUMW-1:0]   exact_w, ed_w;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [SUM_W:0]    sum_ext;
  logic [SUMW-1:0]   max_q, max_d;

  assign accept    = in_valid && in_ready_q;
  assign win_clear = (state_q == ST_IDLE) && start;

  approx_err_dist u_dist (
    .a_i     (a_q),
    .b_i     (b_q),
    .y_i     (y_q),
    .exact_o (exact_w),
    .ed_o    (ed_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      smp_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_q    <= ST_RUN;
          in_ready_q <= 1'b1;
          smp_cnt_q  <= '0;
        end
        ST_RUN: if (accept) begin
          smp_cnt_q <= smp_cnt_q + 16'd1;
          if (smp_cnt_q == 16'(WIN - 1)) begin
            state_q    <= ST_DRAIN;
            in_ready_q <= 1'b0;
          end
        end
        // The last sample sits in stage 1 with stage 0 empty: it is
        // accumulated on this edge, so results are complete next cycle.
        ST_DRAIN: if (s1_v_q && !s0_v_q) begin
          state_q     <= ST_DONE;
          res_valid_q <= 1'b1;
        end
        ST_DONE: if (res_ready) begin
          state_q     <= ST_IDLE;
          res_valid_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_v_q <= 1'b0;
      s1_v_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      y_q    <= '0;
      ed_q   <= '0;
    end else begin
      s0_v_q <= accept;
      s1_v_q <= s0_v_q;
      ed_q   <= ed_w;
      if (accept) begin
        a_q <= a;
        b_q <= b;
        y_q <= y_apx;
      end
    end
  end

  always_comb begin
    sum_ext = {1'b0, sum_q} + (SUM_W + 1)'(ed_q);
    sum_d   = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
    cnt_d   = ((ed_q != '0) && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    max_d   = (ed_q > max_q) ? ed_q : max_q;
  end

  always_ff @(posedge clk) begin
    if (rst || win_clear) begin
      cnt_q <= '0;
      sum_q <= '0;
      max_q <= '0;
    end else if (s1_v_q) begin
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      max_q <= max_d;
    end
  end

`ifdef APPROX_ERR_HIST_EN
  logic [HIST_BINS-1:0][CNT_W-1:0] hist_q;
  logic [2:0]                      bin_w;

  assign bin_w = (ed_q >= SUMW'(7)) ? 3'd7 : ed_q[2:0];

  always_ff @(posedge clk) begin
    if (rst || win_clear) begin
      hist_q <= '0;
    end else if (s1_v_q && (hist_q[bin_w] != '1)) begin
      hist_q[bin_w] <= hist_q[bin_w] + 1'b1;
    end
  end

  assign hist = hist_q;
`endif

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign err_cnt   = cnt_q;
  assign err_sum   = sum_q;
  assign err_max   = max_q;
  assign dbg_state = state_q;
endmodule
